// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response sequencer.
package puf_pkg;

  localparam int CHAL_W            = 3;
  localparam int N_CHAL            = 8;
  localparam int TMR_W             = 16;
  localparam int DEF_WINDOW_CYCLES = 256;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } puf_state_e;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter with terminal-count flag; times both the oscillator
// window and the settle interval. Load N-1 to get an N-cycle interval.
module puf_window_timer
  import puf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [TMR_W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/puf_response_sequencer.sv
// PUF response sequencer: walks challenges 0..7, times the oscillator window
// and settle interval, compares the two bank counts and packs the results.
// Optional build macro PUF_RESP_MAJORITY_EN: three measurements per challenge,
// result bit is the majority vote.
//
// state  | meaning
// IDLE   | waiting for start; resp holds last word
// CLEAR  | one cycle, counters cleared, oscillators off
// RUN    | oscillators enabled for WINDOW_CYCLES
// SETTLE | oscillators off for SETTLE_CYCLES before sampling
// SAMPLE | compare cnt_a > cnt_b, store bit, advance challenge
// DONE   | one cycle, resp_valid asserted
module puf_response_sequencer
  import puf_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_cnt_a,
  input  logic [CNT_W-1:0]  i_cnt_b,
  output logic              o_osc_en,
  output logic              o_cnt_clr,
  output logic [CHAL_W-1:0] o_challenge,
  output logic              o_busy,
  output logic [N_CHAL-1:0] o_resp,
  output logic              o_resp_valid
);

  localparam logic [TMR_W-1:0]  WIN_LOAD  = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SET_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CHAL_W-1:0] LAST_CHAL = CHAL_W'(N_CHAL - 1);

  puf_state_e        r_state, w_state_nxt;
  logic              r_osc_en, r_cnt_clr, r_busy, r_resp_valid;
  logic [CHAL_W-1:0] r_challenge;
  logic [N_CHAL-1:0] r_resp;
  logic              w_tmr_load, w_tmr_tc;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_bit, w_result, w_meas_last, w_chal_last;

  assign w_bit       = (i_cnt_a > i_cnt_b);
  assign w_chal_last = (r_challenge == LAST_CHAL);

  puf_window_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tmr_tc)
  );

`ifdef PUF_RESP_MAJORITY_EN
  logic [1:0] r_rep;
  logic [1:0] r_vote;
  logic [2:0] w_votes;

  assign w_votes     = {w_bit, r_vote};
  assign w_meas_last = (r_rep == 2'd2);
  assign w_result    = (w_votes[0] & w_votes[1]) | (w_votes[0] & w_votes[2]) |
                       (w_votes[1] & w_votes[2]);

  // Track repeat number and keep the first two votes of each challenge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rep  <= '0;
      r_vote <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_rep  <= '0;
      r_vote <= '0;
    end else if (r_state == ST_SAMPLE) begin
      if (w_meas_last) begin
        r_rep <= '0;
      end else begin
        r_vote[r_rep[0]] <= w_bit;
        r_rep            <= r_rep + 2'd1;
      end
    end
  end
`else
  assign w_meas_last = 1'b1;
  assign w_result    = w_bit;
`endif

  // Next-state decode and timer load for the coming interval.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = WIN_LOAD;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        w_state_nxt = ST_RUN;
        w_tmr_load  = 1'b1;
        w_tmr_val   = WIN_LOAD;
      end
      ST_RUN: begin
        if (w_tmr_tc) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SET_LOAD;
        end
      end
      ST_SETTLE: if (w_tmr_tc) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = (w_meas_last && w_chal_last) ? ST_DONE : ST_CLEAR;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; outputs registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_osc_en     <= 1'b0;
      r_cnt_clr    <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_challenge  <= '0;
      r_resp       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_osc_en     <= (w_state_nxt == ST_RUN);
      r_cnt_clr    <= (w_state_nxt == ST_CLEAR);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_DONE);
      if (r_state == ST_IDLE && i_start) begin
        r_challenge <= '0;
        r_resp      <= '0;
      end else if (r_state == ST_SAMPLE && w_meas_last) begin
        r_resp[r_challenge] <= w_result;
        if (!w_chal_last) r_challenge <= r_challenge + CHAL_W'(1);
      end
    end
  end

  assign o_osc_en     = r_osc_en;
  assign o_cnt_clr    = r_cnt_clr;
  assign o_challenge  = r_challenge;
  assign o_busy       = r_busy;
  assign o_resp       = r_resp;
  assign o_resp_valid = r_resp_valid;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Directed bench for puf_response_sequencer with a 16-cycle window and
// 2-cycle settle (20 cycles per measurement).
module tb_puf_response_sequencer;

  localparam int W = 16;
  localparam int S = 2;
  localparam int P = W + S + 2;
`ifdef PUF_RESP_MAJORITY_EN
  localparam int N_MEAS = 3;
`else
  localparam int N_MEAS = 1;
`endif
  localparam int N_CLR = 8 * N_MEAS;
  localparam int LAT   = N_CLR * P + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cnt_a = 8'h00;
  logic [7:0] cnt_b = 8'h00;
  logic       o_osc_en, o_cnt_clr, o_busy, o_resp_valid;
  logic [2:0] o_challenge;
  logic [7:0] o_resp;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int clr_cnt = 0, osc_cnt = 0, rv_cnt = 0, busy_cnt = 0;
  int run_len = 0, bad_runs = 0, chal_err = 0;
  int meas, ch, rep;

  puf_response_sequencer #(
    .WINDOW_CYCLES (W),
    .SETTLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_cnt_a      (cnt_a),
    .i_cnt_b      (cnt_b),
    .o_osc_en     (o_osc_en),
    .o_cnt_clr    (o_cnt_clr),
    .o_challenge  (o_challenge),
    .o_busy       (o_busy),
    .o_resp       (o_resp),
    .o_resp_valid (o_resp_valid)
  );

  always #5 clk = ~clk;

  // Monitor output activity and drive bank counts from the measurement index
  // derived from the number of counter clears seen.
  always @(negedge clk) begin
    if (o_cnt_clr) clr_cnt++;
    if (o_resp_valid) rv_cnt++;
    if (o_busy) busy_cnt++;
    if (o_osc_en) begin
      osc_cnt++;
      run_len++;
      if (clr_cnt > 0 && o_challenge !== 3'(((clr_cnt - 1) / N_MEAS) % 8)) chal_err++;
    end else if (run_len != 0) begin
      if (run_len != W) bad_runs++;
      run_len = 0;
    end
    meas = (clr_cnt > 0) ? clr_cnt - 1 : 0;
    ch   = (meas / N_MEAS) % 8;
    rep  = meas % N_MEAS;
    case (mode)
      0: begin
        if (ch % 2 == 0) begin cnt_a = 8'h40; cnt_b = 8'h3F; end
        else             begin cnt_a = 8'h10; cnt_b = 8'h20; end
      end
      1: begin cnt_a = 8'h80; cnt_b = 8'h80; end
      2: begin
        if (ch == 3 && rep != 1) begin cnt_a = 8'h55; cnt_b = 8'h54; end
        else                     begin cnt_a = 8'h54; cnt_b = 8'h55; end
      end
      default: begin
        if (ch % 2 == 0) begin cnt_a = 8'hFF; cnt_b = 8'h00; end
        else             begin cnt_a = 8'h80; cnt_b = 8'h7F; end
      end
    endcase
  end

  task automatic test_reset();
    int rv_seen, busy_seen;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_osc_en !== 1'b0) begin failures++; $display("FAIL reset_osc_en got %b exp 0", o_osc_en); end
    checks++; if (o_cnt_clr !== 1'b0) begin failures++; $display("FAIL reset_cnt_clr got %b exp 0", o_cnt_clr); end
    checks++; if (o_challenge !== 3'd0) begin failures++; $display("FAIL reset_challenge got %0d exp 0", o_challenge); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_resp !== 8'h00) begin failures++; $display("FAIL reset_resp got %h exp 00", o_resp); end
    checks++; if (o_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got %b exp 0", o_resp_valid); end
    rv_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (o_resp_valid !== 1'b0) rv_seen++;
      if (o_busy !== 1'b0) busy_seen++;
    end
    checks++; if (rv_seen != 0) begin failures++; $display("FAIL idle_resp_valid got %0d pulses exp 0", rv_seen); end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL idle_busy got %0d cycles exp 0", busy_seen); end
  endtask

  task automatic do_run(input int m, input bit restart, input logic [7:0] exp_resp, input string nm);
    int n, first_v;
    logic [7:0] v_resp;
    logic busy1, clr1, busy_done, busy_after;
    mode = m;
    clr_cnt = 0; osc_cnt = 0; rv_cnt = 0; run_len = 0; bad_runs = 0; chal_err = 0;
    first_v = 0; v_resp = 8'h00; busy_done = 1'b0; busy_after = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    busy1 = o_busy;
    clr1 = o_cnt_clr;
    while (n < LAT + 10) begin
      if (o_resp_valid === 1'b1 && first_v == 0) begin first_v = n; v_resp = o_resp; end
      if (n == LAT) busy_done = o_busy;
      if (n == LAT + 1) busy_after = o_busy;
      if (restart) begin
        if (n == 40) start = 1'b1;
        else if (n == 41) start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL %s busy_cycle1 got %b exp 1", nm, busy1); end
    checks++; if (clr1 !== 1'b1) begin failures++; $display("FAIL %s clr_cycle1 got %b exp 1", nm, clr1); end
    checks++; if (first_v != LAT) begin failures++; $display("FAIL %s valid_cycle got %0d exp %0d", nm, first_v, LAT); end
    checks++; if (v_resp !== exp_resp) begin failures++; $display("FAIL %s resp got %h exp %h", nm, v_resp, exp_resp); end
    checks++; if (rv_cnt != 1) begin failures++; $display("FAIL %s valid_pulses got %0d exp 1", nm, rv_cnt); end
    checks++; if (clr_cnt != N_CLR) begin failures++; $display("FAIL %s clr_pulses got %0d exp %0d", nm, clr_cnt, N_CLR); end
    checks++; if (osc_cnt != N_CLR * W) begin failures++; $display("FAIL %s osc_cycles got %0d exp %0d", nm, osc_cnt, N_CLR * W); end
    checks++; if (bad_runs != 0) begin failures++; $display("FAIL %s osc_window_len got %0d bad exp 0", nm, bad_runs); end
    checks++; if (chal_err != 0) begin failures++; $display("FAIL %s challenge_seq got %0d errs exp 0", nm, chal_err); end
    checks++; if (busy_done !== 1'b1) begin failures++; $display("FAIL %s busy_in_done got %b exp 1", nm, busy_done); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL %s busy_after_done got %b exp 0", nm, busy_after); end
    checks++; if (o_resp !== exp_resp) begin failures++; $display("FAIL %s resp_hold got %h exp %h", nm, o_resp, exp_resp); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 70) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (o_osc_en !== 1'b1) begin failures++; $display("FAIL midrst_pre_osc_en got %b exp 1", o_osc_en); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_osc_en !== 1'b0) begin failures++; $display("FAIL midrst_osc_en got %b exp 0", o_osc_en); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", o_busy); end
    checks++; if (o_resp !== 8'h00) begin failures++; $display("FAIL midrst_resp got %h exp 00", o_resp); end
    checks++; if (o_challenge !== 3'd0) begin failures++; $display("FAIL midrst_challenge got %0d exp 0", o_challenge); end
    rv_cnt = 0;
    busy_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (rv_cnt != 0) begin failures++; $display("FAIL midrst_no_valid got %0d exp 0", rv_cnt); end
    checks++; if (busy_cnt != 0) begin failures++; $display("FAIL midrst_stays_idle got %0d exp 0", busy_cnt); end
    do_run(0, 1'b0, 8'h55, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    logic v_at_lat, busy_idle, clr_restart;
    mode = 0;
    rv_cnt = 0;
    v_at_lat = 1'b0; busy_idle = 1'b1; clr_restart = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (n < LAT + 3) begin
      if (n == LAT) v_at_lat = o_resp_valid;
      if (n == LAT + 1) busy_idle = o_busy;
      if (n == LAT + 2) clr_restart = o_cnt_clr;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++; if (v_at_lat !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got %b exp 1", v_at_lat); end
    checks++; if (busy_idle !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got %b exp 0", busy_idle); end
    checks++; if (clr_restart !== 1'b1) begin failures++; $display("FAIL b2b_restart_clr got %b exp 1", clr_restart); end
    repeat (LAT + 10) @(posedge clk);
    #1;
    checks++; if (rv_cnt != 2) begin failures++; $display("FAIL b2b_valid_pulses got %0d exp 2", rv_cnt); end
    checks++; if (o_resp !== 8'h55) begin failures++; $display("FAIL b2b_resp got %h exp 55", o_resp); end
  endtask

  initial begin
    test_reset();
    do_run(0, 1'b0, 8'h55, "basic");
    do_run(1, 1'b0, 8'h00, "tie");
    do_run(3, 1'b0, 8'hFF, "unsigned_max");
    do_run(0, 1'b1, 8'h55, "start_busy");
    do_run(2, 1'b0, 8'h08, "vote_pattern");
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
